// File: rtl/seq_detect_pkg.sv
// Shared state encoding and sizing helper for the serial pattern detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Width of a counter that must reach pat_w-1.
  function automatic int fcnt_width(input int pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && !(&q_q)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with loadable pattern, overlap and Mealy/registered options.
// Optional match counter enabled by defining SEQ_DETECT_MATCH_COUNT_EN.
//
// state | meaning
// IDLE  | en low, history and fill count held at zero
// FILL  | en high, fewer than PAT_W-1 bits of history collected
// RUN   | en high, history full, every accepted bit is compared
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] RST_PAT = '1,
  parameter int               OVERLAP = 1,
  parameter int               MEALY   = 1,
  parameter int unsigned      CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cnt_clr,
  output logic             match,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = fcnt_width(PAT_W);
  localparam logic [FW-1:0] FCNT_MAX = FW'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [PAT_W-1:0] window;
  logic             accept;
  logic             full;
  logic             hit;
  state_e           state;

  always_comb begin
    accept = en && in_valid && !pat_load;
    full   = (fcnt_q == FCNT_MAX);
    window = {hist_q, in};
    hit    = accept && full && (window == pat_q);
    pat_d  = pat_load ? pat_in : pat_q;
    hist_d = hist_q;
    fcnt_d = fcnt_q;
    // Disable and reload both discard any partial sequence; the pattern itself survives disable.
    if (!en || pat_load) begin
      hist_d = '0;
      fcnt_d = '0;
    end else if (accept) begin
      hist_d = window[PAT_W-2:0];
      if (hit && (OVERLAP == 0)) begin
        fcnt_d = '0;
      end else if (!full) begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state = IDLE;
    if (en) begin
      state = full ? RUN : FILL;
    end
  end

  assign state_o = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q  <= RST_PAT;
      hist_q <= '0;
      fcnt_q <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fcnt_q <= fcnt_d;
    end
  end

  if (MEALY != 0) begin : g_mealy
    assign match = hit && !reset;
  end else begin : g_registered
    logic match_q, match_d;

    assign match_d = hit;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        match_q <= 1'b0;
      end else begin
        match_q <= match_d;
      end
    end

    assign match = match_q;
  end

`ifdef SEQ_DETECT_MATCH_COUNT_EN
  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (hit),
    .clr  (cnt_clr),
    .q    (match_count)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

endmodule
